// File: rtl/cutie_params.sv
`default_nettype none
// ============================================================================
// Package : cutie_params
// Brief   : Shared ternary types, pooling FSM encoding and trit helpers for
//           the OCU output path.
// Rev     : 1.0  initial release
// ============================================================================
package cutie_params;

    // Two-bit two's-complement trit: 2'b11=-1, 2'b00=0, 2'b01=+1
    typedef logic signed [1:0] trit_t;

    localparam trit_t TRIT_NEG  = 2'sb11;
    localparam trit_t TRIT_ZERO = 2'sb00;
    localparam trit_t TRIT_POS  = 2'sb01;

    // 2x2 pooling walk: left/right pixel of a pair on an even/odd row
    typedef enum logic [1:0] {
        EVEN_L = 2'd0,
        EVEN_R = 2'd1,
        ODD_L  = 2'd2,
        ODD_R  = 2'd3
    } pool_state_e;

    // Signed maximum of two trits
    function automatic trit_t trit_max(input trit_t a, input trit_t b);
        return (a > b) ? a : b;
    endfunction

    // Map a raw 2-bit code onto a legal trit; the unused code 2'b10 reads as 0
    function automatic trit_t trit_from_raw(input logic [1:0] raw);
        case (raw)
            2'b11:   return TRIT_NEG;
            2'b01:   return TRIT_POS;
            default: return TRIT_ZERO;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cutie_pool_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cutie_pool_fifo
// Brief   : Synchronous DEPTH x 2-bit row buffer holding even-row pair maxima.
//           Push/pop/flush, full/empty flags. The occupancy count is only
//           built when CUTIE_POOL_USAGE_EN is defined; otherwise it reads 0.
// Rev     : 1.0  initial release
// ============================================================================
module cutie_pool_fifo
    import cutie_params::*;
#(
    parameter int DEPTH    = 16,
    parameter int PTRWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  trit_t             data_i,
    input  logic              pop_i,
    output trit_t             data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTRWIDTH:0] count_o
);

    localparam logic [PTRWIDTH-1:0] c_last_ptr = PTRWIDTH'(DEPTH - 1);
    localparam logic [PTRWIDTH-1:0] c_ptr_one  = PTRWIDTH'(1);

    trit_t               r_mem [DEPTH];
    logic [PTRWIDTH-1:0] r_wptr;
    logic [PTRWIDTH-1:0] r_rptr;
    logic                r_wphase;
    logic                r_rphase;
    logic                w_do_push;
    logic                w_do_pop;

    // Equal pointers: phase bits tell a wrapped (full) buffer from an empty one
    assign full_o    = (r_wptr == r_rptr) && (r_wphase != r_rphase);
    assign empty_o   = (r_wptr == r_rptr) && (r_wphase == r_rphase);
    assign w_do_push = push_i && !full_o && !flush_i;
    assign w_do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o    = empty_o ? TRIT_ZERO : r_mem[r_rptr];

    // Storage array write port
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Read/write pointers with wrap-phase bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_wphase <= 1'b0;
            r_rphase <= 1'b0;
        end else if (flush_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_wphase <= 1'b0;
            r_rphase <= 1'b0;
        end else begin
            if (w_do_push) begin
                if (r_wptr == c_last_ptr) begin
                    r_wptr   <= '0;
                    r_wphase <= ~r_wphase;
                end else begin
                    r_wptr <= r_wptr + c_ptr_one;
                end
            end
            if (w_do_pop) begin
                if (r_rptr == c_last_ptr) begin
                    r_rptr   <= '0;
                    r_rphase <= ~r_rphase;
                end else begin
                    r_rptr <= r_rptr + c_ptr_one;
                end
            end
        end
    end

`ifdef CUTIE_POOL_USAGE_EN
    logic [PTRWIDTH:0] r_count;

    // Occupancy counter; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (PTRWIDTH+1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - (PTRWIDTH+1)'(1);
        end
    end

    assign count_o = r_count;
`else
    assign count_o = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/cutie_ocu_pool.sv
`default_nettype none
// ============================================================================
// Module  : cutie_ocu_pool
// Brief   : Per-lane 2x2/stride-2 ternary max pooling after the OCU threshold
//           stage, or a registered pass-through when pooling is off. Even rows
//           are reduced to pair maxima in a row FIFO; odd rows combine with it
//           to emit one pooled pixel per four inputs.
//           Optional macro CUTIE_POOL_USAGE_EN exposes the FIFO fill level.
// Rev     : 1.0  initial release
// ============================================================================
module cutie_ocu_pool
    import cutie_params::*;
#(
    parameter int IMAGEWIDTH        = 32,
    parameter int POOLING_FIFODEPTH = IMAGEWIDTH / 2,
    parameter int USAGEWIDTH        = (POOLING_FIFODEPTH > 1) ? $clog2(POOLING_FIFODEPTH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        layer_start_i,
    input  logic                        pool_en_i,
    input  logic [$clog2(IMAGEWIDTH):0] width_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [1:0]                  data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [1:0]                  data_o,
    output logic                        config_err_o,
    output logic [USAGEWIDTH:0]         usage_o
);

    localparam int                   c_width_w   = $clog2(IMAGEWIDTH) + 1;
    localparam logic [c_width_w-1:0] c_max_width = c_width_w'(IMAGEWIDTH);
    localparam logic [c_width_w-1:0] c_col_one   = c_width_w'(1);

    // Layer configuration
    logic                 r_pool_en;
    logic [c_width_w-1:0] r_width;
    logic                 r_cfg_err;

    // Pooling walk
    pool_state_e          r_state;
    logic [c_width_w-1:0] r_col;
    trit_t                r_hold;

    // Output register
    logic                 r_valid;
    trit_t                r_data;

    trit_t                w_pix;
    trit_t                w_pair_max;
    trit_t                w_pool_max;
    trit_t                w_out;
    trit_t                w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [USAGEWIDTH:0]  w_fifo_count;
    logic                 w_slot_free;
    logic                 w_ready;
    logic                 w_beat;
    logic                 w_last_col;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_emit;
    logic                 w_cfg_err_next;

    assign w_pix       = trit_from_raw(data_i);
    assign w_slot_free = !r_valid || ready_i;
    assign w_beat      = valid_i && w_ready && !layer_start_i && !r_cfg_err;
    assign w_last_col  = (r_col + c_col_one) == r_width;
    assign w_push      = w_beat && r_pool_en && (r_state == EVEN_R);
    assign w_pop       = w_beat && r_pool_en && (r_state == ODD_R);
    assign w_emit      = w_beat && (!r_pool_en || (r_state == ODD_R));
    assign w_pair_max  = trit_max(r_hold, w_pix);
    assign w_pool_max  = trit_max(w_pair_max, w_fifo_rdata);
    assign w_out       = r_pool_en ? w_pool_max : w_pix;

    assign ready_o      = w_ready;
    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign config_err_o = r_cfg_err;
    assign usage_o      = w_fifo_count;

    // Width legality for the incoming layer; pooling also needs an even width
    always_comb begin
        w_cfg_err_next = (width_i == '0) || (width_i > c_max_width);
        if (pool_en_i && width_i[0]) begin
            w_cfg_err_next = 1'b1;
        end
    end

    // Only beats that produce an output wait for the output slot
    always_comb begin
        w_ready = 1'b1;
        if (!r_cfg_err) begin
            if (!r_pool_en) begin
                w_ready = w_slot_free;
            end else begin
                case (r_state)
                    EVEN_R:  w_ready = !w_fifo_full;
                    ODD_R:   w_ready = w_slot_free;
                    default: w_ready = 1'b1;
                endcase
            end
        end
    end

    // Latch layer configuration and the sticky error on layer_start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pool_en <= 1'b0;
            r_width   <= '0;
            r_cfg_err <= 1'b0;
        end else if (layer_start_i) begin
            r_pool_en <= pool_en_i;
            r_width   <= width_i;
            r_cfg_err <= w_cfg_err_next;
        end
    end

    // Pooling walk: column counter, pair hold register and row parity
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= EVEN_L;
            r_col   <= '0;
            r_hold  <= TRIT_ZERO;
        end else if (layer_start_i) begin
            r_state <= EVEN_L;
            r_col   <= '0;
            r_hold  <= TRIT_ZERO;
        end else if (w_beat) begin
            r_col <= w_last_col ? '0 : r_col + c_col_one;
            if (r_pool_en) begin
                case (r_state)
                    EVEN_L: begin
                        r_hold  <= w_pix;
                        r_state <= EVEN_R;
                    end
                    EVEN_R:  r_state <= w_last_col ? ODD_L : EVEN_L;
                    ODD_L: begin
                        r_hold  <= w_pix;
                        r_state <= ODD_R;
                    end
                    ODD_R:   r_state <= w_last_col ? EVEN_L : ODD_L;
                    default: r_state <= EVEN_L;
                endcase
            end
        end
    end

    // Single-stage output register; holds data while downstream stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= TRIT_ZERO;
        end else if (layer_start_i) begin
            r_valid <= 1'b0;
        end else if (w_emit) begin
            r_valid <= 1'b1;
            r_data  <= w_out;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    cutie_pool_fifo #(
        .DEPTH    (POOLING_FIFODEPTH),
        .PTRWIDTH (USAGEWIDTH)
    ) u_row_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (layer_start_i),
        .push_i  (w_push),
        .data_i  (w_pair_max),
        .pop_i   (w_pop),
        .data_o  (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    // A legal width never fills the row buffer before the odd row starts
    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(valid_i && !layer_start_i && !r_cfg_err && r_pool_en &&
          (r_state == EVEN_R) && w_fifo_full));

    // Every odd-row pair has a buffered even-row partner
    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_pop && w_fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_cutie_ocu_pool.sv
`default_nettype none
// ============================================================================
// Module  : tb_cutie_ocu_pool
// Brief   : Directed bench for cutie_ocu_pool. A pixel-index model predicts
//           valid/data/ready/error/usage every cycle; literal expectations pin
//           the pooled results of each directed frame.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cutie_ocu_pool;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       layer_start_i = 1'b0;
    logic       pool_en_i = 1'b0;
    logic [5:0] width_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [1:0] data_i = 2'b00;
    logic       valid_o;
    logic       ready_i = 1'b1;
    logic [1:0] data_o;
    logic       config_err_o;
    logic [4:0] usage_o;

    always #5 clk_i = ~clk_i;

    cutie_ocu_pool dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .layer_start_i (layer_start_i),
        .pool_en_i     (pool_en_i),
        .width_i       (width_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .config_err_o  (config_err_o),
        .usage_o       (usage_o)
    );

    int checks = 0;
    int errors = 0;
    int out_log[$];

    // Model state: latched config, pixel index within the layer, even-row copy
    int m_pool_en, m_width, m_err, m_n, m_prev, m_valid, m_data, m_cnt;
    int m_row[32];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [1:0] r);
        case (r)
            2'b11:   return -1;
            2'b01:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v < 0) return 2'b11;
        if (v > 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cfg_bad(input int p, input int w);
        if (w == 0 || w > 32) return 1;
        if (p != 0 && (w % 2) == 1) return 1;
        return 0;
    endfunction

    function automatic int pat0(input int i);
        return ((i * 7) % 3) - 1;
    endfunction

    function automatic int pat1(input int i);
        return ((i * 5 + 1) % 3) - 1;
    endfunction

    task automatic model_reset();
        m_pool_en = 0; m_width = 0; m_err = 0; m_n = 0;
        m_prev = 0; m_valid = 0; m_data = 0; m_cnt = 0;
    endtask

    // Beat acceptance: only the second pixel of an odd-row pair needs the slot
    function automatic int model_ready();
        int slot;
        if (m_err != 0) return 1;
        slot = (m_valid == 0 || ready_i) ? 1 : 0;
        if (m_pool_en == 0) return slot;
        if (((m_n / m_width) % 2) == 1 && ((m_n % m_width) % 2) == 1) return slot;
        return 1;
    endfunction

    // Apply what the coming clock edge does to the model
    task automatic model_advance(input int rdy);
        int p, col, row, val, emit;
        emit = 0;
        val  = 0;
        if (layer_start_i) begin
            m_pool_en = int'(pool_en_i);
            m_width   = int'(width_i);
            m_err     = cfg_bad(m_pool_en, m_width);
            m_n = 0; m_valid = 0; m_cnt = 0;
        end else begin
            if (valid_i && rdy != 0 && m_err == 0) begin
                p = dec(data_i);
                if (m_pool_en == 0) begin
                    emit = 1;
                    val  = p;
                end else begin
                    col = m_n % m_width;
                    row = (m_n / m_width) % 2;
                    if (row == 0) begin
                        m_row[col] = p;
                        if ((col % 2) == 1) m_cnt++;
                    end else if ((col % 2) == 0) begin
                        m_prev = p;
                    end else begin
                        emit = 1;
                        val  = imax(imax(m_row[col-1], m_row[col]), imax(m_prev, p));
                        m_cnt--;
                    end
                    m_n++;
                end
            end
            if (emit != 0) begin
                m_valid = 1;
                m_data  = val;
            end else if (ready_i) begin
                m_valid = 0;
            end
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle
    initial begin
        int rdy;
        model_reset();
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                model_reset();
                check("rst_valid_o", int'(valid_o), 0);
                check("rst_data_o", int'(data_o), 0);
                check("rst_ready_o", int'(ready_o), 1);
                check("rst_config_err_o", int'(config_err_o), 0);
                check("rst_usage_o", int'(usage_o), 0);
            end else begin
                rdy = model_ready();
                check("valid_o", int'(valid_o), m_valid);
                if (m_valid != 0) check("data_o", int'(data_o), int'(enc(m_data)));
                check("ready_o", int'(ready_o), rdy);
                check("config_err_o", int'(config_err_o), m_err);
`ifdef CUTIE_POOL_USAGE_EN
                check("usage_o", int'(usage_o), m_cnt);
`else
                check("usage_o", int'(usage_o), 0);
`endif
                if (valid_o && ready_i) out_log.push_back(dec(data_o));
                model_advance(rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic layer(input logic p, input logic [5:0] w);
        layer_start_i = 1'b1;
        pool_en_i     = p;
        width_i       = w;
        tick();
        layer_start_i = 1'b0;
    endtask

    task automatic send_raw(input logic [1:0] raw);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i  = raw;
        #1;
        while (!ready_o && n < 40) begin
            tick();
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready_o=%0d required=1 at %0t", ready_o, $time);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic send(input int v);
        send_raw(enc(v));
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, "_count"}, out_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_log.size(); i++) begin
            check(name, out_log[i], exp[i]);
        end
    endtask

    int cfg_p[6] = '{1, 0, 0, 1, 0, 1};
    int cfg_w[6] = '{5, 5, 0, 0, 33, 4};
    int cfg_e[6] = '{1, 0, 1, 1, 1, 0};

    initial begin
        int exp_q[$];
        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check("lit_rst_valid_o", int'(valid_o), 0);
        check("lit_rst_ready_o", int'(ready_o), 1);
        check("lit_rst_usage_o", int'(usage_o), 0);
        rst_ni = 1'b1;
        tick();

        // Pass-through, width 4
        out_log.delete();
        layer(1'b0, 6'd4);
        send(1); send(0); send(-1); send(1);
        tick(); tick();
        exp_q = '{1, 0, -1, 1};
        check_log("lit_passthrough", exp_q);

        // Pool 4x2
        out_log.delete();
        layer(1'b1, 6'd4);
        send(-1); send(1); send(0); send(0);
        check("lit_pool_row0_silent", out_log.size(), 0);
`ifdef CUTIE_POOL_USAGE_EN
        check("lit_pool_usage_peak", int'(usage_o), 2);
`endif
        send(-1); send(-1); send(0); send(-1);
        tick(); tick();
        exp_q = '{1, 0};
        check_log("lit_pool4x2", exp_q);

        // Illegal code 2'b10 reads as zero
        out_log.delete();
        layer(1'b1, 6'd2);
        send_raw(2'b10); send_raw(2'b10); send_raw(2'b11); send_raw(2'b11);
        tick(); tick();
        exp_q = '{0};
        check_log("lit_illegal_code", exp_q);

        // Backpressure, width 2
        out_log.delete();
        layer(1'b1, 6'd2);
        send(0); send(-1); send(-1); send(1);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("lit_bp_valid_hold", int'(valid_o), 1);
            check("lit_bp_data_hold", int'(data_o), 1);
            tick();
        end
        send(-1); send(-1); send(-1);
        valid_i = 1'b1;
        data_i  = 2'b11;
        #1;
        check("lit_bp_oddr_stall", int'(ready_o), 0);
        tick(); tick();
        ready_i = 1'b1;
        #1;
        check("lit_bp_oddr_release", int'(ready_o), 1);
        tick();
        valid_i = 1'b0;
        tick(); tick();
        exp_q = '{1, -1};
        check_log("lit_backpressure", exp_q);

        // Configuration errors; the first case also streams discarded beats
        out_log.delete();
        for (int c = 0; c < 6; c++) begin
            layer(cfg_p[c] != 0, 6'(cfg_w[c]));
            check("lit_cfg_err", int'(config_err_o), cfg_e[c]);
            if (c == 0) begin
                for (int b = 0; b < 10; b++) send((b % 3) - 1);
                tick();
                check("lit_cfg_err_no_output", out_log.size(), 0);
            end
        end

        // Mid-row restart then a full 32x2 frame
        layer(1'b1, 6'd32);
        for (int i = 0; i < 10; i++) send(pat1(i));
`ifdef CUTIE_POOL_USAGE_EN
        check("lit_restart_usage_partial", int'(usage_o), 5);
`else
        check("lit_restart_usage_partial", int'(usage_o), 0);
`endif
        layer(1'b1, 6'd32);
        check("lit_restart_usage_flushed", int'(usage_o), 0);
        out_log.delete();
        for (int i = 0; i < 32; i++) send(pat0(i));
        check("lit_restart_row0_silent", out_log.size(), 0);
        for (int i = 0; i < 32; i++) send(pat1(i));
        tick(); tick();
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(imax(imax(pat0(2*k), pat0(2*k+1)), imax(pat1(2*k), pat1(2*k+1))));
        end
        check_log("lit_frame32", exp_q);

        // Asynchronous reset while an ODD_R beat is stalled behind a held output
        layer(1'b1, 6'd2);
        send(0); send(0); send(0); send(0);
        ready_i = 1'b0;
        send(1); send(1); send(1);
        valid_i = 1'b1;
        data_i  = 2'b01;
        #1;
        check("lit_prereset_valid_o", int'(valid_o), 1);
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        #1;
        check("lit_async_valid_o", int'(valid_o), 0);
        check("lit_async_data_o", int'(data_o), 0);
        check("lit_async_ready_o", int'(ready_o), 1);
        check("lit_async_config_err_o", int'(config_err_o), 0);
        check("lit_async_usage_o", int'(usage_o), 0);
        tick();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        tick();
        out_log.delete();
        send(-1);
        tick(); tick();
        exp_q = '{-1};
        check_log("lit_after_reset_passthrough", exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cutie_ocu_pool.md
Name: cutie_ocu_pool

Overview:
- Downstream of the OCU threshold stage. Consumes one ternary activation per accepted beat, in raster order, for one output-channel lane.
- Performs optional 2x2/stride-2 max pooling before write-back to activation memory.
- Even rows are buffered as pair-maxima in a row FIFO of depth POOLING_FIFODEPTH. Odd rows combine with the FIFO contents to emit pooled pixels.
- With pooling disabled, the block is a registered pass-through.

Parameters:
- IMAGEWIDTH, 32, maximum image width in pixels.
- POOLING_FIFODEPTH, IMAGEWIDTH/2, row-buffer entries.
- USAGEWIDTH, $clog2(POOLING_FIFODEPTH) (min 1), FIFO pointer width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- layer_start_i  in  1  pulse: latch config, flush state
- pool_en_i  in  1  pooling enable, sampled on layer_start_i
- width_i  in  $clog2(IMAGEWIDTH)+1  image width, sampled on layer_start_i
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- data_i  in  2  ternary: 2'b11=-1, 2'b00=0, 2'b01=+1 (2'b10 illegal)
- valid_o  out  1  output valid
- ready_i  in  1  downstream ready
- data_o  out  2  ternary result
- config_err_o  out  1  sticky config error for the current layer
- usage_o  out  USAGEWIDTH+1  FIFO fill level (see Optional Feature)

Behaviour:
- Reset values:
  - valid_o=0, data_o=2'b00, config_err_o=0, usage_o=0, ready_o=1.
  - FIFO empty; col=0; row parity=EVEN; latched pool_en=0.
- Max operation: signed 2-bit compare. Illegal 2'b10 on data_i is treated as 0.
- Output register is a single stage.
  - ready_o = !valid_o || ready_i on beats that produce an output.
  - ready_o = 1 on beats that only push to the FIFO, unless the FIFO is full.
- layer_start_i (takes priority over any same-cycle beat, which is dropped):
  - Clears FIFO, col, parity, valid_o and config_err_o.
  - Latches pool_en_i and width_i.
  - config_err_o=1 if pool_en_i=1 and width_i is odd, 0, or >IMAGEWIDTH.
  - config_err_o=1 if pool_en_i=0 and width_i is 0 or >IMAGEWIDTH.
- Error mode: ready_o=1, all beats discarded, valid_o stays 0 until the next layer_start_i.
- Pass-through (pool_en=0): each accepted beat loads data_o next cycle with valid_o=1. Latency 1, throughput 1/cycle.
- Pooling FSM states: EVEN_L, EVEN_R, ODD_L, ODD_R.
  - EVEN_L: store pixel in a hold register -> EVEN_R.
  - EVEN_R: push max(hold, pixel) to FIFO. If col+1==width -> ODD_L, else -> EVEN_L.
  - ODD_L: hold pixel -> ODD_R.
  - ODD_R: requires output slot free. Pop FIFO; data_o <= max(hold, pixel, pop), valid_o=1 next cycle. If col+1==width -> EVEN_L, else -> ODD_L.
- col increments per accepted beat and wraps to 0 at width-1.
- Output timing: latency 1 cycle after the second odd-row pixel of each pair. One output per 4 inputs.
- Boundaries:
  - FIFO full with an EVEN_R beat pending: ready_o=0. Unreachable with legal width; checked by assertion.
  - FIFO empty in ODD_R: assertion; output uses 0 for the pop.
  - Odd image height: leftover FIFO entries persist and are flushed by the next layer_start_i.
  - valid_o held && !ready_i: data_o stable; ODD_R beats stalled; even-row beats still accepted.
  - Async reset mid-row: all state returns to reset values immediately.

Optional Feature:
- Macro CUTIE_POOL_USAGE_EN.
- Defined: usage_o reports the FIFO entry count, 0..POOLING_FIFODEPTH. It is updated the cycle after each push/pop. Simultaneous push and pop leaves it unchanged.
- Undefined: usage_o tied to 0 and no counter logic is instantiated.

Decomposition:
- Shared package cutie_params gains:
  - trit_t (logic signed [1:0]);
  - constants TRIT_NEG/TRIT_ZERO/TRIT_POS;
  - pool_state_e enum;
  - a trit_max function.
- One sub-module: cutie_pool_fifo, a synchronous FIFO of POOLING_FIFODEPTH x 2 bits with push/pop/full/empty and an optional count.

Test Plan:
- Pass-through: pool_en=0, width=4, stream +1,0,-1,+1 with ready_i=1 -> identical values out, each 1 cycle later; 4 outputs.
- Pool 4x2: pool_en=1, width=4, rows [-1,+1,0,0] and [-1,-1,0,-1] -> outputs +1 then 0. No valid_o during row 0. usage_o peaks at 2 (macro on).
- Backpressure: width=2, 2x2 frame, ready_i=0 for 5 cycles after valid_o -> data_o stable. Next frame's ODD_R beat sees ready_o=0. Row-0 beats still accepted.
- Config error: pool_en=1, width=5 -> config_err_o=1. 10 beats give ready_o=1 and no valid_o. layer_start with width=4 clears the error.
- Mid-row restart: width=32; push 10 row-0 pixels, then layer_start -> usage_o=0, FIFO state re-begins at EVEN_L. A full 32x2 frame yields 16 correct maxima.
- Reset mid-operation: assert rst_ni=0 during ODD_R with valid_o=1 -> valid_o=0 immediately and all outputs at reset values.
